// File: rtl/fir_sample_sequencer_pkg.sv
// Shared types and default widths for the FIR sample sequencer.
// The FIR_SEQ_LOOP_EN macro (optional looping playback) is handled in the interface and top.
package fir_seq_pkg;

  localparam int FIR_X_W    = 8;
  localparam int DEF_DATA_W = FIR_X_W;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_GAP_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/fir_sample_sequencer_if.sv
// Host/filter-facing bundle of the sample sequencer: table writes, playback control, sample stream.
// With FIR_SEQ_LOOP_EN defined an extra 'loop' control bit is carried.
interface fir_sample_sequencer_if
  import fir_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int GAP_W  = DEF_GAP_W
) ();

  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [DATA_W-1:0] wr_data;
  logic                     start;
  logic                     abort;
  logic [ADDR_W:0]          len;
  logic [GAP_W-1:0]         gap;
`ifdef FIR_SEQ_LOOP_EN
  logic                     loop;
`endif
  logic signed [DATA_W-1:0] x_out;
  logic                     x_valid;
  logic                     busy;
  logic                     done;

`ifdef FIR_SEQ_LOOP_EN
  modport master (
    output wr_en, wr_addr, wr_data, start, abort, len, gap, loop,
    input  x_out, x_valid, busy, done
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, start, abort, len, gap, loop,
    output x_out, x_valid, busy, done
  );
`else
  modport master (
    output wr_en, wr_addr, wr_data, start, abort, len, gap,
    input  x_out, x_valid, busy, done
  );
  modport slave (
    input  wr_en, wr_addr, wr_data, start, abort, len, gap,
    output x_out, x_valid, busy, done
  );
`endif

endinterface

// File: rtl/fir_sample_sequencer_mem.sv
// Sample table: one synchronous write port (blocked while playing), one asynchronous read port.
module fir_seq_mem
  import fir_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                     clk,
  input  logic                     i_wr_en,
  input  logic                     i_busy,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic signed [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0]        i_rd_addr,
  output logic signed [DATA_W-1:0] o_rd_data
);

  logic signed [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en && !i_busy) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fir_sample_sequencer.sv
// Replays a preloaded sample table into the FIR x_in port with programmable zero gaps.
// Defining FIR_SEQ_LOOP_EN adds a 'loop' control that repeats the table until abort/rst.
module fir_sample_sequencer
  import fir_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int GAP_W  = DEF_GAP_W
) (
  input logic                  clk,
  input logic                  rst,
  fir_sample_sequencer_if.slave bus
);

  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]  IDX_ONE = (ADDR_W+1)'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  seq_state_e               r_state;
  logic [ADDR_W:0]          r_idx;
  logic [ADDR_W:0]          r_len;
  logic [GAP_W-1:0]         r_gap;
  logic [GAP_W-1:0]         r_gap_cnt;
  logic signed [DATA_W-1:0] r_x_out;
  logic                     r_x_valid;
  logic                     r_busy;
  logic                     r_done;

  logic [ADDR_W:0]          w_len;
  logic                     w_last;
  logic                     w_loop;
  logic signed [DATA_W-1:0] w_rd_data;

  assign w_len  = (bus.len > DEPTH_L) ? DEPTH_L : bus.len;
  assign w_last = (r_idx == (r_len - IDX_ONE));

`ifdef FIR_SEQ_LOOP_EN
  logic r_loop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_loop <= 1'b0;
    end else if (r_state == IDLE && bus.start && !bus.abort) begin
      r_loop <= bus.loop;
    end
  end

  assign w_loop = r_loop;
`else
  assign w_loop = 1'b0;
`endif

  fir_seq_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .i_wr_en   (bus.wr_en),
    .i_busy    (r_busy),
    .i_wr_addr (bus.wr_addr),
    .i_wr_data (bus.wr_data),
    .i_rd_addr (r_idx[ADDR_W-1:0]),
    .o_rd_data (w_rd_data)
  );

  // idx always advances past an emitted sample, so in GAP idx==len means the last one went out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_len     <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_x_out   <= '0;
      r_x_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (bus.abort) begin
      r_state   <= IDLE;
      r_x_out   <= '0;
      r_x_valid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_x_out   <= '0;
      r_x_valid <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_len <= w_len;
            r_gap <= bus.gap;
            r_idx <= '0;
            if (w_len == '0) begin
              r_state <= DONE;
            end else begin
              r_state <= EMIT;
              r_busy  <= 1'b1;
            end
          end
        end
        EMIT: begin
          r_x_out   <= w_rd_data;
          r_x_valid <= 1'b1;
          r_idx     <= r_idx + IDX_ONE;
          if (r_gap != '0) begin
            r_state   <= GAP;
            r_gap_cnt <= r_gap;
          end else if (w_last) begin
            if (w_loop) begin
              r_idx <= '0;
            end else begin
              r_state <= DONE;
              r_busy  <= 1'b0;
            end
          end
        end
        GAP: begin
          if (r_gap_cnt <= GAP_ONE) begin
            if (r_idx != r_len) begin
              r_state <= EMIT;
            end else if (w_loop) begin
              r_idx   <= '0;
              r_state <= EMIT;
            end else begin
              r_state <= DONE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt - GAP_ONE;
          end
        end
        DONE: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.x_out   = r_x_out;
  assign bus.x_valid = r_x_valid;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule

// File: tb/tb_fir_sample_sequencer.sv
// Directed bench for fir_sample_sequencer: per-cycle timing checks plus a sample scoreboard.
// The looping scenario is compiled in only when FIR_SEQ_LOOP_EN is defined.
module tb_fir_sample_sequencer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int GAP_W  = 8;

  logic clk;
  logic rst;

  int cmpCount = 0;
  int errCount = 0;

  logic signed [DATA_W-1:0] model [DEPTH];
  logic signed [DATA_W-1:0] sbQ [$];
  logic signed [DATA_W-1:0] expSample;
  int tableInit [DEPTH] = '{50, 0, 0, 0, 50, 50, 50, 50, 20, 30, 40, 50, 60, 70, 80, 90};

  fir_sample_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .GAP_W(GAP_W)) bus ();

  fir_sample_sequencer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .GAP_W  (GAP_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every valid sample must match the oldest expected sample pushed at start time
  always @(negedge clk) begin
    if (!rst && bus.x_valid === 1'b1) begin
      cmpCount++;
      if (sbQ.size() == 0) begin
        errCount++;
        $error("[TB] FAIL sample: observed x_out=%0d with x_valid=1, expected no sample", bus.x_out);
      end else begin
        expSample = sbQ.pop_front();
        assert (bus.x_out === expSample) else begin
          errCount++;
          $error("[TB] FAIL sample: observed x_out=%0d expected=%0d", bus.x_out, expSample);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int k, input logic expValid,
                             input logic expBusy, input logic expDone);
    cmpCount++;
    assert (bus.x_valid === expValid) else begin
      errCount++;
      $error("[TB] FAIL %s k=%0d x_valid observed=%0b expected=%0b", tag, k, bus.x_valid, expValid);
    end
    cmpCount++;
    assert (bus.busy === expBusy) else begin
      errCount++;
      $error("[TB] FAIL %s k=%0d busy observed=%0b expected=%0b", tag, k, bus.busy, expBusy);
    end
    cmpCount++;
    assert (bus.done === expDone) else begin
      errCount++;
      $error("[TB] FAIL %s k=%0d done observed=%0b expected=%0b", tag, k, bus.done, expDone);
    end
    if (!expValid) begin
      cmpCount++;
      assert (bus.x_out === 8'sd0) else begin
        errCount++;
        $error("[TB] FAIL %s k=%0d x_out observed=%0d expected=0", tag, k, bus.x_out);
      end
    end
  endtask

  task automatic checkDrained(input string tag);
    cmpCount++;
    assert (sbQ.size() == 0) else begin
      errCount++;
      $error("[TB] FAIL %s scoreboard observed=%0d pending expected=0", tag, sbQ.size());
    end
    sbQ.delete();
  endtask

  task automatic writeTable(input int addr, input int data);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(addr);
    bus.wr_data = DATA_W'(data);
    tick();
    bus.wr_en   = 1'b0;
    model[addr] = DATA_W'(data);
  endtask

  // k counts cycles after the start edge: k=1 is the first playback state, sample i shows at 2+i*(gap+1)
  task automatic applyStimulus(input string tag, input int lenReq, input int gapReq,
                               input int abortK, input int wrK);
    int   effLen, period, doneK, lastK;
    logic expValid, expBusy, expDone;
    effLen = (lenReq > DEPTH) ? DEPTH : lenReq;
    period = gapReq + 1;
    doneK  = 2 + effLen * period;
    lastK  = (abortK >= 0) ? abortK + 3 : doneK + 2;
    for (int i = 0; i < effLen; i++) begin
      if (abortK < 0 || (2 + i * period) <= abortK) sbQ.push_back(model[i]);
    end
    bus.len   = (ADDR_W+1)'(lenReq);
    bus.gap   = GAP_W'(gapReq);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    for (int k = 1; k <= lastK; k++) begin
      if (abortK >= 0 && k > abortK) begin
        expValid = 1'b0;
        expBusy  = 1'b0;
        expDone  = 1'b0;
      end else begin
        expValid = (k >= 2) && (((k - 2) % period) == 0) && (((k - 2) / period) < effLen);
        expBusy  = (k <= effLen * period);
        expDone  = (abortK < 0) && (k == doneK);
      end
      checkOutput(tag, k, expValid, expBusy, expDone);
      if (k == abortK) bus.abort = 1'b1;
      if (k == wrK) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = '0;
        bus.wr_data = 8'sd99;
      end
      tick();
      bus.abort = 1'b0;
      bus.wr_en = 1'b0;
    end
    checkDrained(tag);
  endtask

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.len     = '0;
    bus.gap     = '0;
`ifdef FIR_SEQ_LOOP_EN
    bus.loop    = 1'b0;
`endif
    tick();
    tick();
    rst = 1'b0;
    $display("[TB] reset released");
    for (int k = 0; k < 4; k++) begin
      checkOutput("reset", k, 1'b0, 1'b0, 1'b0);
      tick();
    end

    for (int a = 0; a < DEPTH; a++) writeTable(a, tableInit[a]);
    applyStimulus("full16", 16, 0, -1, -1);
    applyStimulus("gap2", 4, 2, -1, -1);
    applyStimulus("len0", 0, 0, -1, -1);
    applyStimulus("abort", 16, 0, 6, 3);
    applyStimulus("replay", 1, 0, -1, -1);

    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.len   = 5'd4;
    bus.gap   = 8'd0;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      checkOutput("abortStart", k, 1'b0, 1'b0, 1'b0);
      tick();
    end

    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd1;
    bus.wr_data = 8'sd77;
    model[1]    = 8'sd77;
    applyStimulus("wrStart", 2, 0, -1, -1);
    applyStimulus("clamp", 31, 0, -1, -1);

`ifdef FIR_SEQ_LOOP_EN
    writeTable(0, 1);
    writeTable(1, 2);
    writeTable(2, 3);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 3; i++) sbQ.push_back(model[i]);
    end
    bus.loop  = 1'b1;
    bus.len   = 5'd3;
    bus.gap   = 8'd0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      checkOutput("loop", k, (k >= 2 && k <= 10), (k <= 10), 1'b0);
      if (k == 10) bus.abort = 1'b1;
      tick();
      bus.abort = 1'b0;
    end
    bus.loop = 1'b0;
    checkDrained("loop");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
    $finish;
  end

endmodule

// File: doc/fir_sample_sequencer.md
Name: fir_sample_sequencer

Overview:
Sample-source block that drives the FIR filter input. It is the transmitter for the filter's x_in port. Host logic preloads a small sample table, then triggers playback. The block emits one sample per emit slot, with a programmable number of zero-stuffed gap cycles between samples. It replaces bench-only stimulus loops so impulse, step and ramp sequences can be replayed in hardware.

Parameters:
DATA_W, 8, sample width; matches the FIR input width.
DEPTH, 16, number of sample table entries.
ADDR_W, 4, table address width; must equal clog2(DEPTH).
GAP_W, 8, width of the inter-sample gap counter.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
wr_en  in  1  table write strobe.
wr_addr  in  ADDR_W  table write address.
wr_data  in  DATA_W  table write data, signed.
start  in  1  playback trigger; honoured only in IDLE.
abort  in  1  stop playback; return to IDLE.
len  in  ADDR_W+1  number of samples to play, 0..DEPTH; latched at start.
gap  in  GAP_W  zero cycles inserted after each sample; latched at start.
x_out  out  DATA_W  sample to FIR x_in; 0 whenever x_valid=0.
x_valid  out  1  x_out carries a table sample this cycle.
busy  out  1  playback in progress (EMIT or GAP).
done  out  1  one-cycle pulse when playback completes normally.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: x_out=0, x_valid=0, busy=0, done=0, state=IDLE, idx=0, gap_cnt=0. Table contents are not reset.
- All outputs are registered.
- State machine: IDLE, EMIT, GAP, DONE.
- IDLE:
  - When start=1, latch len and gap, and set idx=0.
  - If len=0, go to DONE. Otherwise go to EMIT.
- EMIT:
  - Each cycle in EMIT, x_out<=mem[idx] and x_valid<=1. The registered output appears the cycle after the state is entered.
  - First x_valid therefore occurs 2 cycles after start is sampled.
  - After the emit, if idx=len-1 (last sample): go to DONE when gap=0, else go to GAP. Otherwise increment idx.
  - After a non-last sample: if gap=0, stay in EMIT (back-to-back samples, one per clock); else go to GAP.
- GAP:
  - Load gap_cnt=gap on entry. x_out=0, x_valid=0.
  - Decrement gap_cnt each cycle. When it reaches 1, go to EMIT, or to DONE if the last sample has already been sent.
- DONE: assert done for exactly one cycle, then go to IDLE.
- busy=1 in EMIT and GAP; 0 in IDLE and DONE.
- Table writes:
  - Accepted only when busy=0. Writes while busy are silently dropped.
  - A write and a start in the same IDLE cycle: the write completes first, so playback sees the new data.
- len greater than DEPTH is clamped to DEPTH.
- start while busy is ignored.
- abort:
  - Takes priority over all transitions. Next cycle: state=IDLE, x_valid=0, x_out=0, done stays 0.
  - abort and start in the same IDLE cycle: abort wins and playback does not begin.
- rst mid-playback behaves as abort, and additionally clears all counters.
- Arithmetic: idx is ADDR_W+1 bits internally, so the compare against len cannot wrap.

Optional Feature:
Macro FIR_SEQ_LOOP_EN.
- When defined: adds input port loop (1 bit), latched at start. With loop=1, after the last sample (and its gap) idx wraps to 0 and playback continues indefinitely. done is never pulsed; only abort or rst stops playback.
- When undefined: no loop port; playback is always single-shot as described above.

Decomposition:
- Package fir_seq_pkg holds:
  - State enum: IDLE, EMIT, GAP, DONE.
  - Default widths: DATA_W, ADDR_W, GAP_W.
  - FIR_X_W constant = 8, shared with the filter's x_in width.
- Sub-module fir_seq_mem: DEPTH x DATA_W sample RAM.
  - One synchronous write port, gated by wr_en and !busy.
  - One asynchronous read port addressed by idx.
  - The top level keeps the FSM, counters and the output register.

Test Plan:
1. rst held 2 cycles, then released -> x_out=0, x_valid=0, busy=0, done=0. No activity without start.
2. Load table {50,0,0,0,50,50,50,50,20,30,40,50,60,70,80,90}, len=16, gap=0, pulse start -> 16 consecutive x_valid cycles with exactly that sequence, beginning 2 cycles after start. done pulses once on the cycle after the last sample; busy is high throughout.
3. Same table, len=4, gap=2 -> output pattern 50,0,0,0,0,0,0,0,0,0,0,0 with x_valid on cycles 1,4,7,10 only. done after the final gap.
4. len=0 with start -> no x_valid; done pulses 2 cycles after start; busy stays 0.
5. Playback len=16, gap=0; assert abort on the 5th sample; also attempt wr_en to addr 0 with 99 during playback -> x_valid drops the next cycle, no done. A replay then shows entry 0 still equals 50.
6. With FIR_SEQ_LOOP_EN, loop=1, len=3, table {1,2,3} -> output 1,2,3,1,2,3,... for at least 9 samples with done never asserted. abort then returns the block to IDLE.
